// File: rtl/hps_mailbox_agent_if.sv
// Avalon-MM responder bus bundle for hps_mailbox_agent.
// The master modport is the HPS (initiator) side, slave is the agent side.
interface hps_mailbox_agent_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid, avs_waitrequest
  );
endinterface

// File: rtl/hps_mailbox_agent.sv
// HPS lightweight-bridge mailbox: TX/RX word FIFOs plus STATUS/CONTROL/ID registers.
// Define MAILBOX_IRQ_EN to add the irq output and the CONTROL[3] interrupt enable.
module hps_mailbox_agent #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LVL_W    = $clog2(DEPTH) + 1,
  parameter logic [31:0] ID_VALUE = 32'h4D4F4E49
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  hps_mailbox_agent_if.slave avs,
  output logic [31:0]        tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [31:0]        rx_data,
  input  logic               rx_valid,
  output logic               rx_ready
`ifdef MAILBOX_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_CONTROL = 2'd2,
    ADDR_ID      = 2'd3
  } addr_e;

  logic [31:0] tx_mem_q [DEPTH];
  logic [31:0] rx_mem_q [DEPTH];

  logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [LVL_W-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             readdatavalid_q, readdatavalid_d;

  addr_e addr;
  logic  wr_acc, rd_acc;
  logic  tx_full, tx_empty, rx_full, rx_empty;
  logic  tx_pop, tx_push_req, tx_push, tx_flush, tx_we;
  logic  rx_pop, rx_push, rx_flush, rx_we;
  logic  ovf_set, unf_set, sticky_clr;
  logic [31:0] status_word, control_word;

  // A simultaneous read and write is a protocol violation; the write wins.
  assign addr   = addr_e'(avs.avs_address);
  assign wr_acc = avs.avs_write;
  assign rd_acc = avs.avs_read & ~avs.avs_write;

  assign tx_full  = (tx_level_q == LVL_W'(DEPTH));
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == LVL_W'(DEPTH));
  assign rx_empty = (rx_level_q == '0);

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem_q[tx_rd_ptr_q];
  assign rx_ready = ~rx_full;

  assign tx_flush   = wr_acc & (addr == ADDR_CONTROL) & avs.avs_writedata[0];
  assign rx_flush   = wr_acc & (addr == ADDR_CONTROL) & avs.avs_writedata[1];
  assign sticky_clr = wr_acc & (addr == ADDR_CONTROL) & avs.avs_writedata[2];

  // A full TX FIFO still takes a write when the core frees a slot in the same cycle.
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = wr_acc & (addr == ADDR_DATA);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign ovf_set     = tx_push_req & tx_full & ~tx_pop;
  assign tx_we       = tx_push & ~tx_flush;

  assign rx_push = rx_valid & rx_ready;
  assign rx_pop  = rd_acc & (addr == ADDR_DATA) & ~rx_empty;
  assign unf_set = rd_acc & (addr == ADDR_DATA) & rx_empty;
  assign rx_we   = rx_push & ~rx_flush;

  always_comb begin
    status_word        = '0;
    status_word[0]     = tx_full;
    status_word[1]     = tx_empty;
    status_word[2]     = rx_full;
    status_word[3]     = rx_empty;
    status_word[4]     = ovf_q;
    status_word[5]     = unf_q;
    status_word[15:8]  = 8'(tx_level_q);
    status_word[23:16] = 8'(rx_level_q);
  end

`ifdef MAILBOX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  assign control_word = {28'd0, irq_en_q, 3'b000};
  assign irq          = irq_q;
`else
  assign control_word = 32'd0;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    tx_wr_ptr_d     = tx_wr_ptr_q;
    tx_rd_ptr_d     = tx_rd_ptr_q;
    tx_level_d      = tx_level_q;
    rx_wr_ptr_d     = rx_wr_ptr_q;
    rx_rd_ptr_d     = rx_rd_ptr_q;
    rx_level_d      = rx_level_q;
    readdata_d      = readdata_q;
    readdatavalid_d = rd_acc;

    if (tx_flush) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_level_d  = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
      tx_level_d = tx_level_q + LVL_W'(tx_push) - LVL_W'(tx_pop);
    end

    if (rx_flush) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_level_d  = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
      rx_level_d = rx_level_q + LVL_W'(rx_push) - LVL_W'(rx_pop);
    end

    ovf_d = sticky_clr ? 1'b0 : (ovf_q | ovf_set);
    unf_d = sticky_clr ? 1'b0 : (unf_q | unf_set);

    if (rd_acc) begin
      unique case (addr)
        ADDR_DATA:    readdata_d = rx_empty ? 32'd0 : rx_mem_q[rx_rd_ptr_q];
        ADDR_STATUS:  readdata_d = status_word;
        ADDR_CONTROL: readdata_d = control_word;
        ADDR_ID:      readdata_d = ID_VALUE;
        default:      readdata_d = readdata_q;
      endcase
    end

`ifdef MAILBOX_IRQ_EN
    irq_en_d = irq_en_q;
    if (wr_acc && addr == ADDR_CONTROL) irq_en_d = avs.avs_writedata[3];
    // Built from next-state values so irq tracks the FIFO one cycle after the causing event.
    irq_d = irq_en_d & ((rx_level_d != '0) | ovf_d | unf_d);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tx_wr_ptr_q     <= '0;
      tx_rd_ptr_q     <= '0;
      tx_level_q      <= '0;
      rx_wr_ptr_q     <= '0;
      rx_rd_ptr_q     <= '0;
      rx_level_q      <= '0;
      ovf_q           <= 1'b0;
      unf_q           <= 1'b0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
`ifdef MAILBOX_IRQ_EN
      irq_en_q        <= 1'b0;
      irq_q           <= 1'b0;
`endif
    end else begin
      tx_wr_ptr_q     <= tx_wr_ptr_d;
      tx_rd_ptr_q     <= tx_rd_ptr_d;
      tx_level_q      <= tx_level_d;
      rx_wr_ptr_q     <= rx_wr_ptr_d;
      rx_rd_ptr_q     <= rx_rd_ptr_d;
      rx_level_q      <= rx_level_d;
      ovf_q           <= ovf_d;
      unf_q           <= unf_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
`ifdef MAILBOX_IRQ_EN
      irq_en_q        <= irq_en_d;
      irq_q           <= irq_d;
`endif
    end
  end

  // NOTE: FIFO storage is not reset; levels gate every read, so stale words are never observed.
  always_ff @(posedge clk_clk) begin
    if (tx_we) tx_mem_q[tx_wr_ptr_q] <= avs.avs_writedata;
    if (rx_we) rx_mem_q[rx_wr_ptr_q] <= rx_data;
  end

  assign avs.avs_readdata      = readdata_q;
  assign avs.avs_readdatavalid = readdatavalid_q;
  assign avs.avs_waitrequest   = 1'b0;

endmodule

// File: tb/tb_hps_mailbox_agent.sv
// Self-checking bench for hps_mailbox_agent: directed scenarios plus a randomized run
// against a queue-based reference model. Honours MAILBOX_IRQ_EN when defined.
module tb_hps_mailbox_agent;
  localparam int DEPTH = 16;
  localparam logic [31:0] ID_VAL = 32'h4D4F4E49;

  logic        clk_clk     = 1'b0;
  logic        reset_reset = 1'b1;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready    = 1'b0;
  logic [31:0] rx_data     = '0;
  logic        rx_valid    = 1'b0;
  logic        rx_ready;
`ifdef MAILBOX_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hps_mailbox_agent_if avs ();

  hps_mailbox_agent #(.DEPTH(DEPTH)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .avs         (avs.slave),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
`ifdef MAILBOX_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  // Reference model state
  logic [31:0] tx_m [$];
  logic [31:0] rx_m [$];
  bit          ovf_m, unf_m, en_m;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic bus_idle();
    avs.avs_read      = 1'b0;
    avs.avs_write     = 1'b0;
    avs.avs_address   = 2'd0;
    avs.avs_writedata = '0;
  endtask

  task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
    avs.avs_address = a; avs.avs_writedata = d; avs.avs_write = 1'b1;
    cyc();
    bus_idle();
  endtask

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] d, output logic v);
    avs.avs_address = a; avs.avs_read = 1'b1;
    cyc();
    d = avs.avs_readdata;
    v = avs.avs_readdatavalid;
    bus_idle();
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    cyc();
    reset_reset = 1'b0;
    tx_m.delete(); rx_m.delete();
    ovf_m = 0; unf_m = 0; en_m = 0;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(tx_m.size() == DEPTH) | (32'(tx_m.size() == 0) << 1) |
        (32'(rx_m.size() == DEPTH) << 2) | (32'(rx_m.size() == 0) << 3) |
        (32'(ovf_m) << 4) | (32'(unf_m) << 5) |
        (32'(tx_m.size()) << 8) | (32'(rx_m.size()) << 16);
    return s;
  endfunction

  task automatic test_reset();
    logic [31:0] d; logic v;
    bus_idle();
    avs.avs_read = 1'b1; avs.avs_address = 2'd3;
    do_reset();
    avs.avs_read = 1'b0;
    n_checks++;
    if (avs.avs_readdatavalid !== 1'b0 || avs.avs_readdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdv: rdv=%b rd=%h want rdv=0 rd=0", avs.avs_readdatavalid, avs.avs_readdata);
    end
    n_checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || avs.avs_waitrequest !== 1'b0) begin
      n_fail++; $display("FAIL reset_core: tx_valid=%b rx_ready=%b wait=%b want 0/1/0", tx_valid, rx_ready, avs.avs_waitrequest);
    end
`ifdef MAILBOX_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: irq=%b want 0", irq); end
`endif
    avs_rd(2'd1, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h0000000A) begin
      n_fail++; $display("FAIL reset_status: v=%b d=%h want v=1 d=0000000a", v, d);
    end
    avs_rd(2'd3, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== ID_VAL) begin
      n_fail++; $display("FAIL reset_id: v=%b d=%h want %h", v, d, ID_VAL);
    end
  endtask

  task automatic test_tx_basic();
    logic [31:0] d; logic v;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
    tx_ready = 1'b0;
    avs_wr(2'd0, 32'h11);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 32'h11) begin
      n_fail++; $display("FAIL tx_latency: tx_valid=%b tx_data=%h want 1/00000011", tx_valid, tx_data);
    end
    avs_wr(2'd0, 32'h22);
    avs_wr(2'd0, 32'h33);
    avs_rd(2'd1, d, v);
    n_checks++;
    if (d !== 32'h00000308) begin n_fail++; $display("FAIL tx_level3: status=%h want 00000308", d); end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_w[i]) begin
        n_fail++; $display("FAIL tx_drain%0d: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, exp_w[i]);
      end
      cyc();
    end
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_empty: tx_valid=%b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d; logic v;
    for (int i = 0; i < DEPTH; i++) avs_wr(2'd0, 32'hA000_0000 + 32'(i));
    avs_wr(2'd0, 32'h0000DEAD);
    avs_rd(2'd1, d, v);
    n_checks++;
    if (d !== 32'h00001019) begin n_fail++; $display("FAIL ovf_status: status=%h want 00001019", d); end
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 32'hA000_0000 + 32'(i)) begin
        n_fail++; $display("FAIL ovf_drain%0d: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, 32'hA000_0000 + 32'(i));
      end
      cyc();
    end
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: tx_valid=%b want 0", tx_valid); end
    tx_ready = 1'b0;
    avs_wr(2'd2, 32'h4);
    avs_rd(2'd1, d, v);
    n_checks++;
    if (d !== 32'h0000000A) begin n_fail++; $display("FAIL ovf_clear: status=%h want 0000000a", d); end
  endtask

  task automatic test_rx_read();
    logic [31:0] d; logic v;
    rx_data = 32'hCAFE0001; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    avs_rd(2'd0, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'hCAFE0001) begin
      n_fail++; $display("FAIL rx_read: v=%b d=%h want 1/cafe0001", v, d);
    end
    cyc();
    n_checks++;
    if (avs.avs_readdatavalid !== 1'b0 || avs.avs_readdata !== 32'hCAFE0001) begin
      n_fail++; $display("FAIL rx_rdv_once: rdv=%b rd=%h want 0/cafe0001", avs.avs_readdatavalid, avs.avs_readdata);
    end
    avs_rd(2'd0, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL rx_unf_data: v=%b d=%h want 1/0", v, d); end
    avs_rd(2'd1, d, v);
    n_checks++;
    if (d !== 32'h0000002A) begin n_fail++; $display("FAIL rx_unf_status: status=%h want 0000002a", d); end
    avs_wr(2'd2, 32'h4);
  endtask

  task automatic test_rx_full();
    logic [31:0] d; logic v;
    rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 32'hB000_0000 + 32'(i);
      cyc();
    end
    n_checks++;
    if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: rx_ready=%b want 0", rx_ready); end
    rx_data = 32'hB0B0B0B0;
    avs_rd(2'd0, d, v);
    n_checks++;
    if (d !== 32'hB000_0000 || rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL rx_full_pop: d=%h rx_ready=%b want b0000000/1", d, rx_ready);
    end
    cyc();
    n_checks++;
    if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_refill: rx_ready=%b want 0", rx_ready); end
    rx_valid = 1'b0;
    avs_rd(2'd1, d, v);
    n_checks++;
    if (d !== 32'h00100006) begin n_fail++; $display("FAIL rx_full_status: status=%h want 00100006", d); end
    for (int i = 1; i <= DEPTH; i++) begin
      logic [31:0] e;
      e = (i == DEPTH) ? 32'hB0B0B0B0 : 32'hB000_0000 + 32'(i);
      avs_rd(2'd0, d, v);
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL rx_order%0d: d=%h want %h", i, d, e); end
    end
  endtask

  task automatic test_flush_reset();
    logic [31:0] d; logic v;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) avs_wr(2'd0, 32'hC0 + 32'(i));
    tx_ready = 1'b1;
    avs_wr(2'd2, 32'h1);
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: tx_valid=%b want 0", tx_valid); end
    avs_rd(2'd1, d, v);
    n_checks++;
    if (d !== 32'h0000000A) begin n_fail++; $display("FAIL flush_status: status=%h want 0000000a", d); end
    // Burst into both FIFOs, then reset while the burst is still in flight.
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin rx_data = 32'(i); avs_wr(2'd0, 32'hD0 + 32'(i)); end
    avs.avs_write = 1'b1; avs.avs_address = 2'd0; avs.avs_writedata = 32'hEE;
    do_reset();
    bus_idle(); rx_valid = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_core: tx_valid=%b rx_ready=%b want 0/1", tx_valid, rx_ready);
    end
    avs_rd(2'd1, d, v);
    n_checks++;
    if (d !== 32'h0000000A) begin n_fail++; $display("FAIL midreset_status: status=%h want 0000000a", d); end
    avs_rd(2'd3, d, v);
    n_checks++;
    if (d !== ID_VAL) begin n_fail++; $display("FAIL id: d=%h want %h", d, ID_VAL); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic v;
    do_reset();
    avs_wr(2'd2, 32'h8);
    avs_rd(2'd2, d, v);
`ifdef MAILBOX_IRQ_EN
    n_checks++;
    if (d !== 32'h8 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_en: ctrl=%h irq=%b want 8/0", d, irq); end
    rx_data = 32'h1234; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: irq=%b want 1", irq); end
    avs_rd(2'd0, d, v);
    n_checks++;
    if (irq !== 1'b0 || d !== 32'h1234) begin n_fail++; $display("FAIL irq_fall: irq=%b d=%h want 0/1234", irq, d); end
`else
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ctrl_bit3: ctrl=%h want 0", d); end
`endif
    avs_wr(2'd2, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] last_rd;
    do_reset();
    last_rd = '0;
    for (int i = 0; i < 600; i++) begin
      int op;
      bit exp_rv, tx_pop, rx_push, wr_data, rd_data;
      logic [31:0] exp_rd, wd;
      int tx_n, rx_n;

      n_checks++;
      if (tx_valid !== (tx_m.size() > 0) || rx_ready !== (rx_m.size() < DEPTH) ||
          (tx_m.size() > 0 && tx_data !== tx_m[0])) begin
        n_fail++; $display("FAIL rnd_core%0d: tx_valid=%b tx_data=%h rx_ready=%b tx_n=%0d rx_n=%0d",
                           i, tx_valid, tx_data, rx_ready, tx_m.size(), rx_m.size());
      end

      bus_idle();
      op       = int'($urandom_range(0, 19));
      wd       = $urandom;
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 2) != 0);
      rx_data  = $urandom;
      tx_n = tx_m.size(); rx_n = rx_m.size();
      exp_rv = 0; exp_rd = last_rd; wr_data = 0; rd_data = 0;
      tx_pop  = tx_ready && tx_n > 0;
      rx_push = rx_valid && rx_n < DEPTH;

      if (op < 6) begin
        avs.avs_write = 1; avs.avs_address = 2'd0; avs.avs_writedata = wd; wr_data = 1;
      end else if (op < 11) begin
        avs.avs_read = 1; avs.avs_address = 2'd0; rd_data = 1;
      end else if (op < 13) begin
        avs.avs_read = 1; avs.avs_address = 2'd1; exp_rv = 1; exp_rd = model_status();
      end else if (op == 13) begin
        avs.avs_read = 1; avs.avs_address = 2'd3; exp_rv = 1; exp_rd = ID_VAL;
      end else if (op == 14) begin
        avs.avs_read = 1; avs.avs_write = 1; avs.avs_address = 2'd0; avs.avs_writedata = wd; wr_data = 1;
      end else if (op == 15) begin
        wd = wd & 32'h0000000F;
        avs.avs_write = 1; avs.avs_address = 2'd2; avs.avs_writedata = wd;
      end

      if (rd_data) begin
        exp_rv = 1;
        if (rx_n > 0) exp_rd = rx_m.pop_front();
        else begin exp_rd = 0; unf_m = 1; end
      end
      if (rx_push) rx_m.push_back(rx_data);
      if (tx_pop) void'(tx_m.pop_front());
      if (wr_data) begin
        if (tx_n < DEPTH || tx_pop) tx_m.push_back(wd);
        else ovf_m = 1;
      end
      if (op == 15) begin
        if (wd[0]) tx_m.delete();
        if (wd[1]) rx_m.delete();
        if (wd[2]) begin ovf_m = 0; unf_m = 0; end
        en_m = wd[3];
      end

      cyc();
      if (exp_rv) last_rd = exp_rd;
      n_checks++;
      if (avs.avs_readdatavalid !== exp_rv || avs.avs_readdata !== last_rd) begin
        n_fail++; $display("FAIL rnd_read%0d: rdv=%b rd=%h want %b/%h", i, avs.avs_readdatavalid, avs.avs_readdata, exp_rv, last_rd);
      end
`ifdef MAILBOX_IRQ_EN
      n_checks++;
      if (irq !== (en_m && (rx_m.size() > 0 || ovf_m || unf_m))) begin
        n_fail++; $display("FAIL rnd_irq%0d: irq=%b en=%b rx_n=%0d", i, irq, en_m, rx_m.size());
      end
`endif
    end
    bus_idle(); tx_ready = 0; rx_valid = 0;
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_read();
    test_rx_full();
    test_flush_reset();
    test_irq();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hps_mailbox_agent.md
Name: hps_mailbox_agent

Overview:
- Avalon-MM agent (responder) placed on the HPS lightweight h2f bridge; the HPS is the initiator.
- Provides two 32-bit word FIFOs between the HPS and the stack core.
  - TX FIFO: HPS writes, core drains.
  - RX FIFO: core fills, HPS reads.
- Status, control and ID registers let HPS software poll, flush, and clear errors.

Parameters:
- DEPTH, 16: entries per FIFO; power of two, minimum 2.
- LVL_W, $clog2(DEPTH)+1: width of the level counters.
- ID_VALUE, 32'h4D4F4E49: constant returned by the ID register.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous reset, active-high
- avs_address  in  2  word address: 0 DATA, 1 STATUS, 2 CONTROL, 3 ID
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data
- avs_readdatavalid  out  1  read data valid; fixed latency 1
- avs_waitrequest  out  1  held 0; every access is accepted in one cycle
- tx_data  out  32  head of TX FIFO
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  core accepts tx_data
- rx_data  in  32  word from core
- rx_valid  in  1  core offers rx_data
- rx_ready  out  1  RX FIFO not full
- irq  out  1  interrupt; present only with MAILBOX_IRQ_EN

Behaviour:
- Reset (sync, reset_reset=1 at clk_clk edge):
  - Both FIFOs empty, pointers and levels 0, sticky bits cleared.
  - avs_readdata=0, avs_readdatavalid=0, tx_valid=0, rx_ready=1, irq=0.
  - Reset mid-transfer discards all content; a read accepted in the reset cycle produces no readdatavalid.
- Register reads:
  - A read accepted in cycle N gives avs_readdatavalid=1 for exactly cycle N+1, with avs_readdata registered.
  - avs_readdata holds its last value when readdatavalid=0.
- DATA:
  - Write pushes avs_writedata into TX FIFO.
  - Write when TX is full: word dropped, OVF sticky set.
  - Exception: if the core pops in the same cycle (tx_valid & tx_ready), the write is accepted and the level is unchanged.
  - Read pops the RX head and returns it.
  - Read when RX is empty: returns 0, no pop, UNF sticky set.
- STATUS (read-only; writes ignored):
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] OVF, [5] UNF.
  - [15:8] tx_level, [23:16] rx_level (zero-extended); all other bits 0.
  - Value sampled in the read-accept cycle.
- CONTROL (write):
  - bit0 flushes TX, bit1 flushes RX, bit2 clears OVF/UNF.
  - A flush takes priority over a same-cycle push or pop on that FIFO.
  - Reads return 0 except bit3 (see optional feature).
- ID: read returns ID_VALUE; writes ignored.
- Core side:
  - TX pop when tx_valid & tx_ready.
  - RX push when rx_valid & rx_ready.
  - rx_ready = !rx_full (combinational from level), so pushes into a full FIFO are impossible.
  - An HPS pop and a core push in the same cycle on RX are both performed; the level is unchanged.
- FIFO mechanics:
  - Ordering is FIFO.
  - Pointers wrap modulo DEPTH.
  - Level range is 0..DEPTH.
  - tx_data is the registered head; it is valid the cycle after a push into an empty FIFO. Latency from write to tx_valid is 1 cycle.
- Protocol violation: avs_read and avs_write both high → the write is performed, the read is ignored, and no readdatavalid is produced.

Optional Feature:
- Macro MAILBOX_IRQ_EN.
- Defined:
  - CONTROL bit3 is a read/write IRQ enable, reset 0.
  - irq is registered: irq = enable & (!rx_empty | OVF | UNF), updated each cycle.
  - A CONTROL read returns bit3.
- Undefined:
  - irq port absent.
  - CONTROL bit3 write ignored; it reads 0.

Test Plan:
- Reset, then HPS writes 0x11, 0x22, 0x33 to DATA with tx_ready=0 → STATUS reads tx_level=3; raise tx_ready → tx_data yields 0x11, 0x22, 0x33 on consecutive cycles, then tx_valid=0.
- 16 writes with tx_ready=0, then a 17th write of 0xDEAD → STATUS[0]=1 and OVF=1; drain returns only the first 16 words; CONTROL write 0x4 → OVF=0.
- Core pushes 0xCAFE0001 → HPS read of DATA in cycle N gives readdatavalid=1, readdata=0xCAFE0001 in N+1 only; a second read returns 0 with UNF=1.
- Fill RX to 16 → rx_ready=0; HPS pop in the same cycle the core holds rx_valid → next cycle rx_ready=1, level 15 then 16 after the push; order is preserved.
- Load 5 words into TX, CONTROL write 0x1 in the same cycle as a core pop → tx_level=0 and tx_valid=0 next cycle; assert reset_reset mid-burst → all STATUS levels 0; ID read = 0x4D4F4E49.
- With MAILBOX_IRQ_EN: enable via CONTROL=0x8, core pushes one word → irq=1 one cycle later; HPS pops it → irq=0 the following cycle.
